// File: rtl/alu_writeback.sv
// Execute-stage back end: condition evaluation, NZCV flag commit and a small register-file write queue.
// Optional performance counters (retired/squashed) are enabled by defining ALUWB_PERF_EN.
module alu_writeback #(
    parameter int RBITS = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_s,
    input  logic [3:0]       in_nzcv,
    input  logic [3:0]       in_fmask,
    input  logic [3:0]       in_cond,
    input  logic             in_we,
    input  logic [RBITS-1:0] in_rd,
    output logic             cin,
    output logic [3:0]       flags,
    output logic             rf_valid,
    input  logic             rf_ready,
    output logic [RBITS-1:0] rf_addr,
    output logic [15:0]      rf_data
`ifdef ALUWB_PERF_EN
    ,
    output logic [15:0]      retired,
    output logic [15:0]      squashed
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]       flags_q, flags_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RBITS-1:0] addr_mem_q [DEPTH];
    logic [15:0]      data_mem_q [DEPTH];
    logic             accept, pass, push, pop;

    // ARM condition codes, evaluated against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = cf;
            4'h3:    r = !cf;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = cf && !z;
            4'h9:    r = !cf || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign in_ready = (cnt_q != CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign pass     = cond_pass(in_cond, flags_q);
    assign push     = accept && pass && in_we;
    assign rf_valid = (cnt_q != '0);
    assign pop      = rf_valid && rf_ready;

    // Empty queue drives zeros so the write port reads clean out of reset
    assign rf_addr  = rf_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign rf_data  = rf_valid ? data_mem_q[rd_ptr_q] : '0;
    assign flags    = flags_q;
    assign cin      = flags_q[1];

    always_comb begin
        flags_d = flags_q;
        if (accept && pass)
            flags_d = (in_fmask & in_nzcv) | (~in_fmask & flags_q);
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= in_rd;
            data_mem_q[wr_ptr_q] <= in_s;
        end
    end

`ifdef ALUWB_PERF_EN
    logic [15:0] retired_q, squashed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q  <= '0;
            squashed_q <= '0;
        end else if (accept) begin
            if (pass) retired_q  <= retired_q + 16'd1;
            else      squashed_q <= squashed_q + 16'd1;
        end
    end

    assign retired  = retired_q;
    assign squashed = squashed_q;
`endif

endmodule
